// File: rtl/mux_pkg.sv
// mux_pkg: arbitration mode encodings and the clog2 helper shared by the mux blocks.
package mux_pkg;

    typedef enum logic {MODE_RR, MODE_FIXED} mode_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: wrap-around priority search starting one past ptr; one-hot grant plus index.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 4,
    localparam int SW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] index
);

    logic [SW-1:0] c;
    logic          found;

    always_comb begin
        gnt   = '0;
        index = '0;
        found = 1'b0;
        c     = '0;
        for (int k = 1; k <= N; k++) begin
            c = SW'((int'(ptr) + k) % N);
            if (en && !found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                index  = c;
            end
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-to-1 registered mux, round-robin or sel-driven grant, single output slot.
module rr_mux_n
    import mux_pkg::*;
#(
    parameter int    N    = 4,
    parameter int    W    = 8,
    parameter mode_e MODE = MODE_RR,
    localparam int   SW   = clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    logic [SW-1:0] ptr;
    logic [N-1:0]  rr_gnt;
    logic [N-1:0]  fix_gnt;
    logic [SW-1:0] rr_idx;
    logic [SW-1:0] gidx;
    logic          en;
    logic          xfer;

    // Reset gates the grant so nothing is offered while rst_n is low.
    assign en = rst_n && (!out_valid || out_ready);

    rr_arbiter #(.N(N)) u_arb (
        .req   (in_valid),
        .ptr   (ptr),
        .en    (en),
        .gnt   (rr_gnt),
        .index (rr_idx)
    );

    assign fix_gnt  = (en && int'(sel) < N) ? (in_valid & (N'(1) << sel)) : '0;
    assign in_ready = (MODE == MODE_FIXED) ? fix_gnt : rr_gnt;
    assign gidx     = (MODE == MODE_FIXED) ? sel : rr_idx;
    assign xfer     = |in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= SW'(N - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(gidx)*W +: W];
            out_sel   <= gidx;
            ptr       <= gidx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: scoreboard bench for a round-robin and a fixed-select instance side by side.
module tb_rr_mux_n;
    import mux_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   in_valid = '0, in_ready, f_valid = '0, f_ready;
    logic [N*W-1:0] in_data = '0, f_data = '0;
    logic [1:0]     rr_sel = '0, out_sel, f_sel = '0, f_out_sel;
    logic           out_valid, out_ready = 1'b0, f_out_valid, f_oready = 1'b0;
    logic [W-1:0]   out_data, f_out_data;

    logic [9:0] q[$], fq[$];
    int   n_chk = 0, n_fail = 0;
    int   m_ptr = N - 1;
    bit   m_valid = 1'b0, fm_valid = 1'b0;
    logic [9:0] m_beat = '0, fm_beat = '0;

    rr_mux_n #(.N(N), .W(W), .MODE(MODE_RR)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .sel(rr_sel), .out_valid(out_valid),
        .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
    );

    rr_mux_n #(.N(N), .W(W), .MODE(MODE_FIXED)) u_fx (
        .clk(clk), .rst_n(rst_n), .in_valid(f_valid), .in_data(f_data),
        .in_ready(f_ready), .sel(f_sel), .out_valid(f_out_valid),
        .out_data(f_out_data), .out_sel(f_out_sel), .out_ready(f_oready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: predict grants from the current inputs, then compare after the edge.
    task automatic step();
        logic [N-1:0] g, fg;
        int idx, c;
        g = '0;
        fg = '0;
        idx = -1;
        #2;
        if (rst_n && (!m_valid || out_ready))
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (idx < 0 && in_valid[c]) idx = c;
            end
        if (idx >= 0) begin
            g[idx] = 1'b1;
            q.push_back({idx[1:0], in_data[idx*W +: W]});
        end
        check("rr_ready", {28'd0, in_ready}, {28'd0, g});
        if (rst_n && (!fm_valid || f_oready) && f_valid[f_sel]) begin
            fg[f_sel] = 1'b1;
            fq.push_back({f_sel, f_data[int'(f_sel)*W +: W]});
        end
        check("fx_ready", {28'd0, f_ready}, {28'd0, fg});
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_valid = 1'b0;
            fm_valid = 1'b0;
            m_ptr = N - 1;
            q.delete();
            fq.delete();
        end else begin
            if (idx >= 0) begin
                m_valid = 1'b1;
                m_ptr = idx;
                m_beat = q.pop_front();
            end else if (out_ready) m_valid = 1'b0;
            if (|fg) begin
                fm_valid = 1'b1;
                fm_beat = fq.pop_front();
            end else if (f_oready) fm_valid = 1'b0;
        end
        check("rr_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("fx_valid", {31'd0, f_out_valid}, {31'd0, fm_valid});
        if (m_valid) check("rr_beat", {22'd0, out_sel, out_data}, {22'd0, m_beat});
        if (fm_valid) check("fx_beat", {22'd0, f_out_sel, f_out_data}, {22'd0, fm_beat});
    endtask

    initial begin
        // Reset with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = N'($urandom);
            in_data = $urandom;
            out_ready = 1'($urandom);
            rr_sel = 2'($urandom);
            step();
        end
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'h00);
        check("rst_sel", {30'd0, out_sel}, 32'd0);
        check("rst_ready", {28'd0, in_ready}, 32'd0);

        // Fairness across all channels
        rst_n = 1'b1;
        in_valid = 4'b1111;
        in_data = 32'hA3A2A1A0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("fair_sel", {30'd0, out_sel}, i % N);
            check("fair_data", {24'd0, out_data}, 32'hA0 + (i % N));
        end

        // Skip idle channels
        step();
        check("skip_g1", {30'd0, out_sel}, 32'd1);
        in_valid = 4'b1010;
        step();
        check("skip_g3", {30'd0, out_sel}, 32'd3);
        step();
        check("skip_g1b", {30'd0, out_sel}, 32'd1);

        // Stall with a beat from channel 2
        in_valid = 4'b0000;
        step();
        in_valid = 4'b0100;
        in_data = 32'h00550000;
        out_ready = 1'b0;
        step();
        in_valid = 4'b1111;
        in_data = 32'h33221100;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_data", {24'd0, out_data}, 32'h55);
        end
        out_ready = 1'b1;
        step();
        check("stall_next", {30'd0, out_sel}, 32'd3);

        // Fixed select
        f_sel = 2'd2;
        f_valid = 4'b1111;
        f_oready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            f_data = $urandom;
            #1;
            check("fx_only2", {28'd0, f_ready}, 32'b0100);
            step();
        end
        f_sel = 2'd0;
        step();
        check("fx_sel0", {30'd0, f_out_sel}, 32'd0);

        // Reset mid-stream
        step();
        rst_n = 1'b0;
        step();
        check("mid_rst", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        step();
        check("mid_first", {30'd0, out_sel}, 32'd0);

        // Random traffic on both instances
        for (int i = 0; i < 80; i++) begin
            rst_n = ($urandom_range(0, 29) != 0);
            in_valid = N'($urandom);
            in_data = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            rr_sel = 2'($urandom);
            f_valid = N'($urandom);
            f_data = $urandom;
            f_sel = 2'($urandom);
            f_oready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_mux_n.md
RR_MUX_N -- requirements
Module: rr_mux_n

Interface
- REQ-001 Parameter N, default 4: number of input channels; legal range 2..16.
- REQ-002 Parameter W, default 8: data width per channel; legal range ≥1.
- REQ-003 Parameter MODE, default MODE_RR: MODE_RR selects round-robin arbitration; MODE_FIXED selects by the `sel` port.
- REQ-004 Derived constant SW = clog2(N): width of the select and pointer fields.
- REQ-005 Port `clk`, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-006 Port `rst_n`, input, 1 bit: synchronous, active-low reset.
- REQ-007 Port `in_valid`, input, N bits: bit i high means channel i offers data.
- REQ-008 Port `in_data`, input, N*W bits: channel i occupies bits [i*W +: W].
- REQ-009 Port `in_ready`, output, N bits: bit i high means channel i's beat is accepted this cycle.
- REQ-010 Port `sel`, input, SW bits: channel select, used in MODE_FIXED only.
- REQ-011 Port `out_valid`, output, 1 bit: the output register holds a beat.
- REQ-012 Port `out_data`, output, W bits: the registered data.
- REQ-013 Port `out_sel`, output, SW bits: the source channel of the registered beat.
- REQ-014 Port `out_ready`, input, 1 bit: the downstream consumer accepts the beat.

Function
- REQ-015 Output stage: one register slot; `accept = !out_valid || out_ready`.
- REQ-016 Latency: data accepted in cycle t appears on `out_data` in cycle t+1, with no combinational path from `in_data` to `out_data`.
- REQ-017 At most one `in_ready` bit is high per cycle, and only when `accept` is high and that channel's `in_valid` is high.
- REQ-018 Handshake: a transfer occurs on channel i when `in_valid[i] && in_ready[i]`; at that edge `out_data` and `out_sel` load channel i's data and index, and `out_valid` becomes 1.
- REQ-019 Stall: while `out_valid && !out_ready`, `out_data`, `out_sel` and `out_valid` hold, and `in_ready` is all zero.
- REQ-020 Drain: when `out_valid && out_ready` and no input is granted, `out_valid` becomes 0 on the next edge.
- REQ-021 Simultaneous drain and grant: the register reloads in the same cycle, `out_valid` stays 1, and there is no bubble (full throughput).
- REQ-022 MODE_RR priority: search starts at channel (ptr+1) mod N and wraps past N-1 to 0; the first requesting channel wins.
- REQ-023 MODE_RR pointer update: ptr updates to the granted index only on a transfer; it is unchanged when nothing is granted or the output is stalled.
- REQ-024 MODE_RR fairness: with all channels continuously valid and `out_ready` = 1, grants cycle 0,1,...,N-1,0,...
- REQ-025 MODE_FIXED: only channel `sel` can be granted; `sel` is sampled in the same cycle as the grant; other channels see `in_ready` = 0.
- REQ-026 MODE_FIXED out-of-range `sel` (sel ≥ N, N not a power of 2): no grant, and `in_ready` is all zero.
- REQ-027 `in_valid` is not required to be held by sources, but the block treats a dropped request as simply not granted; there is no error flag.

Reset
- REQ-028 When `rst_n` = 0 at a rising `clk` edge: `out_valid` = 0, `out_data` = 0, `out_sel` = 0, and ptr = N-1, so channel 0 has first priority after reset.
- REQ-029 During reset, `in_ready` is forced to all zero.
- REQ-030 Reset mid-transfer: any beat held in the register is discarded, with no partial state retained.
- REQ-031 The first grant is possible in the first cycle with `rst_n` = 1.

Structure
- REQ-032 Package `mux_pkg` holds the MODE_RR/MODE_FIXED encodings and the clog2 helper.
- REQ-033 Sub-module `rr_arbiter` (parameter N; ports req, ptr, en → one-hot gnt, index) holds the wrap-around priority search; rr_mux_n holds the pointer, output register and mode selection.
- REQ-034 The implementation uses no latches and only one clock domain.

Verification (N=4, W=8)
- REQ-035 Reset: hold `rst_n` = 0 for 2 cycles with random inputs -> `out_valid` = 0, `out_data` = 0x00, `in_ready` = 0000.
- REQ-036 RR fairness: `in_valid` = 1111, data i = 0xA0+i, `out_ready` = 1 -> `out_sel` sequence 0,1,2,3,0 on consecutive cycles, with `out_data` 0xA0..0xA3.
- REQ-037 Skip idle channels: `in_valid` = 1010 after a grant to channel 1 -> next grant is 3, then 1.
- REQ-038 Stall: hold `out_ready` = 0 for 3 cycles with a beat 0x55 from channel 2 -> `out_data` holds 0x55, `in_ready` = 0000, ptr unchanged; on `out_ready` = 1 the next channel (3) is granted in the same cycle.
- REQ-039 MODE_FIXED: `sel` = 2, `in_valid` = 1111 -> only `in_ready[2]` is high each cycle; change `sel` to 0 -> the next beat has `out_sel` = 0.
- REQ-040 Reset mid-stream: assert `rst_n` = 0 while `out_valid` = 1 -> the next cycle has `out_valid` = 0, and the first grant after release goes to channel 0.
